// File: rtl/tt_um_accum_adder.sv
// Accumulating adder/subtractor with a byte-serial operand load, carry chain and result readback.
// Latency: NBYTES+1 cycles from the last operand byte to the updated acc and flags.
// Backpressure: none; busy is reported on uio_out[4], and writes that arrive while busy are dropped.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   ena        : tile enable; while low, every input is ignored and all state holds
//   ui_in      : operand byte (LSB byte first)
//   uio_in     : [0] wr, [1] rd, [2] sub, [3] clr, [7:4] unused
//   uo_out     : accumulator byte selected by the read pointer
//   uio_out    : {ovf, zero, carry, busy, 4'b0}
//   uio_oe     : constant 8'hF0 (upper nibble driven)
module tt_um_accum_adder #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NBYTES = WIDTH / 8;
  localparam int PW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [PW-1:0] LAST = PW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

  state_t                  state, state_nxt;
  logic [NBYTES-1:0][7:0]  acc, op_reg;
  logic [PW-1:0]           wr_ptr, rd_ptr, byte_idx;
  logic                    sub_r, chain_c, msb_cin, carry, ovf, busy, zero;

  logic wr, rd, sub, clr;
  assign wr  = uio_in[0];
  assign rd  = uio_in[1];
  assign sub = uio_in[2];
  assign clr = uio_in[3];

  logic unused;
  assign unused = &{1'b0, uio_in[7:4]};

  // One byte slice of the carry chain. Subtraction is acc + ~op + 1, with
  // the +1 injected as the carry-in of byte 0.
  logic [7:0] a_byte, b_byte;
  logic       cin;
  logic [8:0] sum;
  always_comb begin
    a_byte = acc[byte_idx];
    b_byte = op_reg[byte_idx] ^ {8{sub_r}};
    cin    = (byte_idx == '0) ? sub_r : chain_c;
    sum    = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, cin};
  end

  // Flag condition: carry-out for add, borrow (no carry-out) for sub.
  logic sat_hit;
  assign sat_hit = sub_r ? ~chain_c : chain_c;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (ena) begin
      if (clr) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE:    if (wr && wr_ptr == LAST) state_nxt = ADD;
          ADD:     if (byte_idx == LAST)     state_nxt = COMMIT;
          COMMIT:  state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // FSM: outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      op_reg   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      byte_idx <= '0;
      sub_r    <= 1'b0;
      chain_c  <= 1'b0;
      msb_cin  <= 1'b0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        acc      <= '0;
        op_reg   <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        byte_idx <= '0;
        sub_r    <= 1'b0;
        chain_c  <= 1'b0;
        msb_cin  <= 1'b0;
        carry    <= 1'b0;
        ovf      <= 1'b0;
      end else begin
        if (rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        case (state)
          IDLE: begin
            if (wr) begin
              op_reg[wr_ptr] <= ui_in;
              if (wr_ptr == '0) sub_r <= sub;
              if (wr_ptr == LAST) begin
                wr_ptr   <= '0;
                byte_idx <= '0;
              end else begin
                wr_ptr <= wr_ptr + 1'b1;
              end
            end
          end
          ADD: begin
            // Result overwrites the operand byte just consumed.
            op_reg[byte_idx] <= sum[7:0];
            chain_c          <= sum[8];
            if (byte_idx == LAST) begin
              // Carry into the top bit, recovered from the sum bit.
              msb_cin  <= a_byte[7] ^ b_byte[7] ^ sum[7];
              byte_idx <= '0;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
          COMMIT: begin
            if (SATURATE && sat_hit) acc <= sub_r ? '0 : '1;
            else                     acc <= op_reg;
            carry  <= sat_hit;
            ovf    <= msb_cin ^ chain_c;
            rd_ptr <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign zero    = (acc == '0);
  assign uo_out  = acc[rd_ptr];
  assign uio_out = {ovf, zero, carry, busy, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_accum_adder.sv
module tb_tt_um_accum_adder;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in, ui_w, uio_w;
  logic [7:0] uo0, uio0, oe0, uo1, uio1, oe1, uow, uiow, oew;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m0, m1;
  logic [31:0] mw;
  logic [47:0] sb[$];
  logic [47:0] last_exp;

  always #5 clk = ~clk;

  tt_um_accum_adder #(.WIDTH(16), .SATURATE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo0), .uio_out(uio0), .uio_oe(oe0));

  tt_um_accum_adder #(.WIDTH(16), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo1), .uio_out(uio1), .uio_oe(oe1));

  tt_um_accum_adder #(.WIDTH(32), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_w), .uio_in(uio_w),
    .uo_out(uow), .uio_out(uiow), .uio_oe(oew));

  // Reference: full-width arithmetic, signed overflow from operand/result sign bits.
  function automatic void model(input int w, input bit sat, input logic [63:0] a,
                                input logic [63:0] b, input bit sub,
                                output logic [63:0] r, output logic [7:0] flags);
    logic [63:0] mask, bb;
    logic [64:0] s;
    bit c, v;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    bb   = sub ? (~b & mask) : (b & mask);
    s    = {1'b0, a & mask} + {1'b0, bb} + {64'd0, sub};
    r    = s[63:0] & mask;
    c    = sub ? ~s[w] : s[w];
    v    = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
    if (sat && c) r = sub ? 64'd0 : mask;
    flags = {v, (r == 64'd0), c, 5'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d, input bit sub);
    ui_in  = d;
    uio_in = {5'b0, sub, 2'b01};
    step();
    uio_in = 8'h00;
  endtask

  task automatic wr_byte_w(input logic [7:0] d);
    ui_w  = d;
    uio_w = 8'h01;
    step();
    uio_w = 8'h00;
  endtask

  task automatic rd_pulse();
    uio_in = 8'h02;
    step();
    uio_in = 8'h00;
  endtask

  task automatic clr_all();
    uio_in = 8'h08;
    step();
    uio_in = 8'h00;
    m0 = '0;
    m1 = '0;
  endtask

  task automatic do_op(input logic [15:0] op, input bit sub, input bit push);
    logic [63:0] r0, r1;
    logic [7:0]  f0, f1;
    if (push) begin
      model(16, 1'b0, {48'd0, m0}, {48'd0, op}, sub, r0, f0);
      model(16, 1'b1, {48'd0, m1}, {48'd0, op}, sub, r1, f1);
      m0 = r0[15:0];
      m1 = r1[15:0];
      last_exp = {r0[15:0], f0, r1[15:0], f1};
      sb.push_back(last_exp);
    end
    wr_byte(op[7:0], sub);
    wr_byte(op[15:8], sub);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (uio0[4] && n < 40) begin
      n++;
      step();
    end
  endtask

  // Waits for idle, reads both accumulators via rd pulses (pointer ends back at 0),
  // and pops the matching scoreboard entry.
  task automatic settle_and_read(output bit ok, output logic [47:0] obs, output logic [47:0] exp);
    int k;
    logic [7:0] lo0, lo1, f0, f1;
    k = 0;
    while (uio0[4] && k < 40) begin
      k++;
      step();
    end
    ok  = !uio0[4];
    lo0 = uo0; lo1 = uo1; f0 = uio0; f1 = uio1;
    rd_pulse();
    obs = {uo0, lo0, f0, uo1, lo1, f1};
    rd_pulse();
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1;
    ui_in = 0; uio_in = 0; ui_w = 0; uio_w = 0;
    m0 = 0; m1 = 0; mw = 0;
    step(); step();
    n_cmp++;
    if ({uo0, uio0, oe0, uo1, uio1, oe1, uow, uiow, oew} !== 72'h0040F0_0040F0_0040F0) begin
      n_bad++;
      $display("FAIL reset_hold got %h %h %h exp 0040f0", {uo0, uio0, oe0}, {uo1, uio1, oe1}, {uow, uiow, oew});
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({uo0, uio0, oe0, uo1, uio1, oe1} !== 48'h0040F0_0040F0) begin
      n_bad++;
      $display("FAIL reset_release got %h %h exp 0040f0", {uo0, uio0, oe0}, {uo1, uio1, oe1});
    end
  endtask

  task automatic test_add();
    int n; bit ok; logic [47:0] obs, exp;
    do_op(16'h1234, 1'b0, 1'b1);
    count_busy(n);
    n_cmp++;
    if (n !== 3) begin n_bad++; $display("FAIL add_busy_cycles got %0d exp 3", n); end
    settle_and_read(ok, obs, exp);
    n_cmp++;
    if (!ok || obs !== exp) begin n_bad++; $display("FAIL add_1234 got %h exp %h ok=%0d", obs, exp, ok); end
    n_cmp++;
    if (uo0 !== 8'h34) begin n_bad++; $display("FAIL add_uo_out got %h exp 34", uo0); end
  endtask

  task automatic test_readback();
    bit ok; logic [47:0] obs, exp;
    logic [7:0] want [3];
    want = '{8'h01, 8'hBE, 8'h01};
    do_op(16'hABCD, 1'b0, 1'b1);
    settle_and_read(ok, obs, exp);
    n_cmp++;
    if (!ok || obs !== exp) begin n_bad++; $display("FAIL add_abcd got %h exp %h ok=%0d", obs, exp, ok); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo0 !== want[i]) begin n_bad++; $display("FAIL readback_%0d got %h exp %h", i, uo0, want[i]); end
      rd_pulse();
    end
    rd_pulse(); // pointer: 2 reads after wrap -> back to 0
  endtask

  task automatic test_saturate();
    bit ok; logic [47:0] obs, exp;
    logic [15:0] ops [4];
    ops = '{16'hFFFF, 16'h0002, 16'h7FFF, 16'h0001};
    clr_all();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) clr_all();
      do_op(ops[i], 1'b0, 1'b1);
      settle_and_read(ok, obs, exp);
      n_cmp++;
      if (!ok || obs !== exp) begin n_bad++; $display("FAIL sat_add_%0d got %h exp %h ok=%0d", i, obs, exp, ok); end
    end
  endtask

  task automatic test_sub();
    bit ok; logic [47:0] obs, exp;
    logic [15:0] ops [4];
    bit          subs [4];
    ops  = '{16'h0005, 16'h0007, 16'h0007, 16'h0007};
    subs = '{1'b0, 1'b1, 1'b0, 1'b1};
    clr_all();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) clr_all();
      do_op(ops[i], subs[i], 1'b1);
      settle_and_read(ok, obs, exp);
      n_cmp++;
      if (!ok || obs !== exp) begin n_bad++; $display("FAIL sub_%0d got %h exp %h ok=%0d", i, obs, exp, ok); end
    end
  endtask

  task automatic test_busy_wr();
    bit ok; logic [47:0] obs, exp;
    clr_all();
    do_op(16'h1111, 1'b0, 1'b1);
    wr_byte(8'hEE, 1'b0);
    settle_and_read(ok, obs, exp);
    n_cmp++;
    if (!ok || obs !== exp) begin n_bad++; $display("FAIL busy_wr_first got %h exp %h ok=%0d", obs, exp, ok); end
    do_op(16'h2222, 1'b0, 1'b1);
    settle_and_read(ok, obs, exp);
    n_cmp++;
    if (!ok || obs !== exp) begin n_bad++; $display("FAIL busy_wr_next got %h exp %h ok=%0d", obs, exp, ok); end
  endtask

  task automatic test_clr_mid();
    bit ok; logic [47:0] obs, exp;
    do_op(16'h4444, 1'b0, 1'b0);
    clr_all();
    n_cmp++;
    if ({uo0, uio0, uo1, uio1} !== 32'h0040_0040) begin
      n_bad++;
      $display("FAIL clr_mid got %h exp 00400040", {uo0, uio0, uo1, uio1});
    end
    do_op(16'h0101, 1'b0, 1'b1);
    settle_and_read(ok, obs, exp);
    n_cmp++;
    if (!ok || obs !== exp) begin n_bad++; $display("FAIL clr_then_add got %h exp %h ok=%0d", obs, exp, ok); end
  endtask

  task automatic test_ena();
    bit ok; logic [47:0] obs, exp;
    ena = 1'b0;
    ui_in = 8'hFF;
    uio_in = 8'h03;
    repeat (3) step();
    uio_in = 8'h00;
    ena = 1'b1;
    sb.push_back(last_exp);
    settle_and_read(ok, obs, exp);
    n_cmp++;
    if (!ok || obs !== exp) begin n_bad++; $display("FAIL ena_low_hold got %h exp %h ok=%0d", obs, exp, ok); end
    do_op(16'h0202, 1'b0, 1'b1);
    settle_and_read(ok, obs, exp);
    n_cmp++;
    if (!ok || obs !== exp) begin n_bad++; $display("FAIL ena_then_add got %h exp %h ok=%0d", obs, exp, ok); end
  endtask

  task automatic test_rst_mid();
    bit ok; logic [47:0] obs, exp;
    do_op(16'h1000, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (uio0[4] !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy got %b exp 1", uio0[4]); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({uo0, uio0, oe0, uo1, uio1, oe1} !== 48'h0040F0_0040F0) begin
      n_bad++;
      $display("FAIL rst_mid_async got %h %h exp 0040f0", {uo0, uio0, oe0}, {uo1, uio1, oe1});
    end
    step();
    rst_n = 1'b1;
    m0 = 0; m1 = 0; mw = 0;
    step();
    do_op(16'h1234, 1'b0, 1'b1);
    settle_and_read(ok, obs, exp);
    n_cmp++;
    if (!ok || obs !== exp) begin n_bad++; $display("FAIL rst_then_add got %h exp %h ok=%0d", obs, exp, ok); end
  endtask

  task automatic test_wide();
    int n;
    logic [63:0] r;
    logic [7:0]  f;
    logic [31:0] ops [2];
    logic [7:0]  want;
    ops = '{32'h0000_1234, 32'h0000_ABCD};
    for (int k = 0; k < 2; k++) begin
      model(32, 1'b0, {32'd0, mw}, {32'd0, ops[k]}, 1'b0, r, f);
      mw = r[31:0];
      for (int i = 0; i < 4; i++) wr_byte_w(ops[k][8*i +: 8]);
      n = 0;
      while (uiow[4] && n < 40) begin
        n++;
        step();
      end
      n_cmp++;
      if (n !== 5) begin n_bad++; $display("FAIL wide_busy_%0d got %0d exp 5", k, n); end
      n_cmp++;
      if (uiow !== f) begin n_bad++; $display("FAIL wide_flags_%0d got %h exp %h", k, uiow, f); end
      for (int i = 0; i < 5; i++) begin
        want = mw[8*(i%4) +: 8];
        n_cmp++;
        if (uow !== want) begin n_bad++; $display("FAIL wide_rd_%0d_%0d got %h exp %h", k, i, uow, want); end
        uio_w = 8'h02;
        step();
        uio_w = 8'h00;
      end
      repeat (3) begin
        uio_w = 8'h02;
        step();
        uio_w = 8'h00;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_readback();
    test_saturate();
    test_sub();
    test_busy_wr();
    test_clr_mid();
    test_ena();
    test_rst_mid();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
